// File: rtl/button_event_scheduler.sv
// -----------------------------------------------------------------------------
// button_event_scheduler
//
// Turns debounced button levels into discrete PRESS / RELEASE / LONG / REPEAT
// events and serialises them onto one valid/ready event port.
//
// Structure:
//   - free-running millisecond prescaler producing a one-cycle tick
//   - one IDLE/DOWN/HOLD detection FSM per button with a 16-bit ms counter
//   - one pending event slot per button
//   - round-robin arbiter feeding a single registered output stage
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_level  in   [NUM_BTN] debounced levels, 1 = pressed (clk domain)
//   enable     in   1 = event detection active; 0 parks every FSM in IDLE
//   evt_valid  out  event available
//   evt_ready  in   consumer ready
//   evt_id     out  [IDW] button index of the event
//   evt_type   out  [2] 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   evt_drop   out  one-cycle pulse when a generated event was discarded
//   btn_held   out  [NUM_BTN] 1 while that button's FSM is in HOLD
//   dbg_state  out  [2*NUM_BTN] FSM state of each button, button i at [2i+:2]
//
// Handshake: an event transfers on a rising edge where evt_valid=1 and
// evt_ready=1. Once evt_valid is raised, evt_id/evt_type stay stable and
// evt_valid stays high until that transfer; evt_valid never depends
// combinationally on evt_ready.
// -----------------------------------------------------------------------------
module button_event_scheduler #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int NUM_BTN   = 4,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int REPEAT_EN = 1,
  localparam int IDW      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BTN-1:0]     btn_level,
  input  logic                   enable,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDW-1:0]         evt_id,
  output logic [1:0]             evt_type,
  output logic                   evt_drop,
  output logic [NUM_BTN-1:0]     btn_held,
  output logic [2*NUM_BTN-1:0]   dbg_state
);

  localparam int TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  localparam logic [15:0] LONG_LAST   = 16'(LONG_MS - 1);
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Millisecond prescaler (runs regardless of enable)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q     [NUM_BTN];
  state_e        state_d     [NUM_BTN];
  logic [15:0]   cnt_q       [NUM_BTN];
  logic [15:0]   cnt_d       [NUM_BTN];
  logic [NUM_BTN-1:0] gen_v;
  logic [1:0]    gen_type    [NUM_BTN];

  logic [NUM_BTN-1:0] pend_v_q, pend_v_d;
  logic [1:0]    pend_type_q [NUM_BTN];
  logic [1:0]    pend_type_d [NUM_BTN];

  logic          evt_valid_q, evt_valid_d;
  logic [IDW-1:0] evt_id_q,   evt_id_d;
  logic [1:0]    evt_type_q,  evt_type_d;
  logic          evt_drop_q,  evt_drop_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic          load_out;
  logic          found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic [NUM_BTN-1:0] grant;

  // ---------------------------------------------------------------------------
  // Per-button detection FSMs (next state + generated event)
  // Release is checked before the tick so it wins a coincident tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      gen_v[i]    = 1'b0;
      gen_type[i] = EV_PRESS;

      if (!enable) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (btn_level[i]) begin
              gen_v[i]    = 1'b1;
              gen_type[i] = EV_PRESS;
              cnt_d[i]    = '0;
              state_d[i]  = ST_DOWN;
            end
          end
          ST_DOWN: begin
            if (!btn_level[i]) begin
              gen_v[i]    = 1'b1;
              gen_type[i] = EV_RELEASE;
              state_d[i]  = ST_IDLE;
            end else if (tick) begin
              if (cnt_q[i] == LONG_LAST) begin
                gen_v[i]    = 1'b1;
                gen_type[i] = EV_LONG;
                cnt_d[i]    = '0;
                state_d[i]  = ST_HOLD;
              end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
              end
            end
          end
          ST_HOLD: begin
            if (!btn_level[i]) begin
              gen_v[i]    = 1'b1;
              gen_type[i] = EV_RELEASE;
              state_d[i]  = ST_IDLE;
            end else if (tick && (REPEAT_EN != 0)) begin
              if (cnt_q[i] == REPEAT_LAST) begin
                gen_v[i]    = 1'b1;
                gen_type[i] = EV_REPEAT;
                cnt_d[i]    = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending slot after last_grant, wrapping.
  // A grant only happens when the output register is free to load.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_out = !evt_valid_q || evt_ready;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    grant    = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NUM_BTN);
      if (!found && pend_v_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (load_out && found) begin
      grant[sel] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending slots. A slot being granted this cycle is free for a new event
  // at the same edge, which keeps one-event-per-cycle throughput.
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_drop_d = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      pend_v_d[i]    = pend_v_q[i] & ~grant[i];
      pend_type_d[i] = pend_type_q[i];
      if (gen_v[i]) begin
        if (!pend_v_q[i] || grant[i]) begin
          pend_v_d[i]    = 1'b1;
          pend_type_d[i] = gen_type[i];
        end else begin
          evt_drop_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_type_d   = evt_type_q;
    last_grant_d = last_grant_q;
    if (load_out) begin
      if (found) begin
        evt_valid_d  = 1'b1;
        evt_id_d     = sel;
        evt_type_d   = pend_type_q[sel];
        last_grant_d = sel;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      pend_v_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_type_q   <= EV_PRESS;
      evt_drop_q   <= 1'b0;
      last_grant_q <= IDW'(NUM_BTN - 1);
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i]     <= ST_IDLE;
        cnt_q[i]       <= '0;
        pend_type_q[i] <= EV_PRESS;
      end
    end else begin
      presc_q      <= presc_d;
      pend_v_q     <= pend_v_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_type_q   <= evt_type_d;
      evt_drop_q   <= evt_drop_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        pend_type_q[i] <= pend_type_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_valid = evt_valid_q;
    evt_id    = evt_id_q;
    evt_type  = evt_type_q;
    evt_drop  = evt_drop_q;
    btn_held  = '0;
    dbg_state = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      btn_held[i]          = (state_q[i] == ST_HOLD);
      dbg_state[2*i +: 2]  = state_q[i];
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_button_event_scheduler
//
// Directed bench for button_event_scheduler with CLK_FREQ=1 MHz (1000-cycle
// ms tick), LONG_MS=5, REPEAT_MS=2, NUM_BTN=4. Two instances share all inputs:
// dut has REPEAT_EN=1, dut_nr has REPEAT_EN=0. Accepted events are logged at
// the falling edge together with the cycle number and compared against a
// hand-built expected queue.
// -----------------------------------------------------------------------------
module tb_button_event_scheduler;

  localparam int NB  = 4;
  localparam int IDW = 2;
  localparam int EW  = IDW + 2;

  localparam logic [1:0] P = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] L = 2'b10;
  localparam logic [1:0] T = 2'b11;

  // ---------------------------------------------------------------------------
  // Clock / reset / signals
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NB-1:0]   btn_level = '0;
  logic            enable = 1'b1;
  logic            evt_ready = 1'b1;

  logic            evt_valid, nr_valid;
  logic [IDW-1:0]  evt_id, nr_id;
  logic [1:0]      evt_type, nr_type;
  logic            evt_drop, nr_drop;
  logic [NB-1:0]   btn_held, nr_held;
  logic [2*NB-1:0] dbg_state, nr_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_scheduler #(
    .CLK_FREQ(1_000_000), .NUM_BTN(NB), .LONG_MS(5), .REPEAT_MS(2), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .enable(enable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .evt_drop(evt_drop), .btn_held(btn_held),
    .dbg_state(dbg_state)
  );

  button_event_scheduler #(
    .CLK_FREQ(1_000_000), .NUM_BTN(NB), .LONG_MS(5), .REPEAT_MS(2), .REPEAT_EN(0)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .enable(enable),
    .evt_valid(nr_valid), .evt_ready(evt_ready), .evt_id(nr_id),
    .evt_type(nr_type), .evt_drop(nr_drop), .btn_held(nr_held),
    .dbg_state(nr_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and monitor
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] obs2_q[$];
  int            obs_t_q[$];
  int            drop_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      obs_q.push_back({evt_id, evt_type});
      obs_t_q.push_back(cyc);
    end
    if (nr_valid && evt_ready) begin
      obs2_q.push_back({nr_id, nr_type});
    end
    if (evt_drop) drop_cnt <= drop_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking and driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs_q.delete();
    obs2_q.delete();
    obs_t_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    btn_level = '0;
    enable    = 1'b1;
    evt_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(2);
    clear_logs();
  endtask

  function automatic int t_at(input int k);
    if (k < obs_t_q.size()) return obs_t_q[k];
    return -1;
  endfunction

  function automatic logic [EW-1:0] ev(input int id, input logic [1:0] ty);
    return {IDW'(id), ty};
  endfunction

  // Compares the chosen observed queue with exp_q, then empties both.
  task automatic compare_sb(input string tag, input bit use_nr);
    int n_obs;
    int n;
    n_obs = use_nr ? obs2_q.size() : obs_q.size();
    check_val({tag, "_count"}, 32'(n_obs), 32'(exp_q.size()));
    n = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check_val($sformatf("%s_ev%0d", tag, k),
                32'(use_nr ? obs2_q[k] : obs_q[k]), 32'(exp_q[k]));
    end
    if (use_nr) obs2_q.delete();
    else begin
      obs_q.delete();
      obs_t_q.delete();
    end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int c0, c1, c2, d0;
    bit in_win;

    // Reset state
    reset_dut();
    check_val("rst_valid", 32'(evt_valid), 0);
    check_val("rst_held",  32'(btn_held),  0);
    check_val("rst_drop",  32'(evt_drop),  0);
    check_val("rst_id",    32'(evt_id),    0);

    // 1: short press/release of button 1
    reset_dut();
    d0 = drop_cnt;
    c0 = cyc;
    btn_level = 4'b0010;
    step(3000);
    c1 = cyc;
    btn_level = 4'b0000;
    step(10);
    check_val("t1_press_lat",   32'(t_at(0) - c0), 2);
    check_val("t1_release_lat", 32'(t_at(1) - c1), 2);
    exp_q.push_back(ev(1, P));
    exp_q.push_back(ev(1, R));
    compare_sb("t1", 1'b0);
    check_val("t1_drop", 32'(drop_cnt - d0), 0);

    // 2: 12 ms hold of button 0, with and without REPEAT
    reset_dut();
    c0 = cyc;
    btn_level = 4'b0001;
    step(3000);
    check_val("t2_held_pre", 32'(btn_held[0]), 0);
    step(4000);
    check_val("t2_held_mid", 32'(btn_held[0]), 1);
    check_val("t2_nr_held_mid", 32'(nr_held[0]), 1);
    step(5000);
    c1 = cyc;
    btn_level = 4'b0000;
    step(10);
    check_val("t2_held_post", 32'(btn_held[0]), 0);
    in_win = ((t_at(1) - t_at(0)) >= 4000) && ((t_at(1) - t_at(0)) <= 5000);
    check_val("t2_long_window", 32'(in_win), 1);
    check_val("t2_rep1_gap", 32'(t_at(2) - t_at(1)), 2000);
    check_val("t2_rep2_gap", 32'(t_at(3) - t_at(1)), 4000);
    check_val("t2_rep3_gap", 32'(t_at(4) - t_at(1)), 6000);
    check_val("t2_release_lat", 32'(t_at(5) - c1), 2);
    exp_q.push_back(ev(0, P));
    exp_q.push_back(ev(0, L));
    exp_q.push_back(ev(0, T));
    exp_q.push_back(ev(0, T));
    exp_q.push_back(ev(0, T));
    exp_q.push_back(ev(0, R));
    compare_sb("t2", 1'b0);
    exp_q.push_back(ev(0, P));
    exp_q.push_back(ev(0, L));
    exp_q.push_back(ev(0, R));
    compare_sb("t2_nr", 1'b1);

    // 3: simultaneous presses, round-robin order
    reset_dut();
    c0 = cyc;
    btn_level = 4'b1101;
    step(10);
    btn_level = 4'b0000;
    step(10);
    c2 = cyc;
    btn_level = 4'b0101;
    step(10);
    btn_level = 4'b0000;
    step(10);
    check_val("t3_p0_time", 32'(t_at(0) - c0), 2);
    check_val("t3_p2_time", 32'(t_at(1) - c0), 3);
    check_val("t3_p3_time", 32'(t_at(2) - c0), 4);
    check_val("t3_b_p0_time", 32'(t_at(6) - c2), 2);
    check_val("t3_b_p2_time", 32'(t_at(7) - c2), 3);
    exp_q.push_back(ev(0, P));
    exp_q.push_back(ev(2, P));
    exp_q.push_back(ev(3, P));
    exp_q.push_back(ev(0, R));
    exp_q.push_back(ev(2, R));
    exp_q.push_back(ev(3, R));
    exp_q.push_back(ev(0, P));
    exp_q.push_back(ev(2, P));
    exp_q.push_back(ev(0, R));
    exp_q.push_back(ev(2, R));
    compare_sb("t3", 1'b0);

    // 4: backpressure, full slot, single drop
    reset_dut();
    d0 = drop_cnt;
    evt_ready = 1'b0;
    btn_level = 4'b0010;
    step(5);
    check_val("t4_valid_a", 32'(evt_valid), 1);
    check_val("t4_id_a",    32'(evt_id),    1);
    check_val("t4_type_a",  32'(evt_type),  32'(P));
    btn_level = 4'b0000;
    step(5);
    btn_level = 4'b0010;
    step(5);
    check_val("t4_valid_b", 32'(evt_valid), 1);
    check_val("t4_id_b",    32'(evt_id),    1);
    check_val("t4_type_b",  32'(evt_type),  32'(P));
    check_val("t4_drop_once", 32'(drop_cnt - d0), 1);
    step(5);
    check_val("t4_drop_still", 32'(drop_cnt - d0), 1);
    evt_ready = 1'b1;
    step(10);
    exp_q.push_back(ev(1, P));
    exp_q.push_back(ev(1, R));
    compare_sb("t4", 1'b0);
    check_val("t4_drop_final", 32'(drop_cnt - d0), 1);

    // 5: enable=0 while held, then re-enable with button still down
    reset_dut();
    btn_level = 4'b0100;
    step(6000);
    check_val("t5_held_on", 32'(btn_held[2]), 1);
    clear_logs();
    enable = 1'b0;
    step(2);
    check_val("t5_held_off", 32'(btn_held[2]), 0);
    step(2998);
    check_val("t5_no_events", 32'(obs_q.size()), 0);
    c1 = cyc;
    enable = 1'b1;
    step(10);
    check_val("t5_press_lat", 32'(t_at(0) - c1), 2);
    exp_q.push_back(ev(2, P));
    compare_sb("t5", 1'b0);

    // 6: asynchronous reset under stall, then re-press after reset
    reset_dut();
    evt_ready = 1'b0;
    btn_level = 4'b1000;
    step(6000);
    check_val("t6_pre_valid", 32'(evt_valid), 1);
    check_val("t6_pre_held",  32'(btn_held[3]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_valid", 32'(evt_valid), 0);
    check_val("t6_rst_held",  32'(btn_held), 0);
    check_val("t6_rst_drop",  32'(evt_drop), 0);
    step(3);
    clear_logs();
    d0 = drop_cnt;
    c1 = cyc;
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step(10);
    check_val("t6_press_lat", 32'(t_at(0) - c1), 2);
    exp_q.push_back(ev(3, P));
    compare_sb("t6", 1'b0);
    check_val("t6_drop", 32'(drop_cnt - d0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
